// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            SZ_D:    return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    // Low address bits rounded down to the natural boundary of the access size
    function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] size);
        logic [3:0] n;
        n = size_bytes(size);
        return off & ~(n[2:0] - 3'd1);
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            SZ_D:    return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: load extraction/extension, store byte merge and
// natural-alignment detection for a single 64-bit doubleword.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [63:0] rd_dword,
    input  logic [63:0] wdata,
    output logic [63:0] load_val,
    output logic [63:0] merged,
    output logic        misaligned
);

    logic [63:0] shifted_s;
    logic [63:0] wshift_s;
    logic [7:0]  mask_s;

    // Extract and extend the load field, merge store bytes, flag misalignment
    always_comb begin
        shifted_s = rd_dword >> {off, 3'b000};
        wshift_s  = wdata << {off, 3'b000};
        mask_s    = byte_mask(size) << off;

        case (size)
            SZ_B:    load_val = sgn ? {{56{shifted_s[7]}},  shifted_s[7:0]}  : {56'd0, shifted_s[7:0]};
            SZ_H:    load_val = sgn ? {{48{shifted_s[15]}}, shifted_s[15:0]} : {48'd0, shifted_s[15:0]};
            SZ_W:    load_val = sgn ? {{32{shifted_s[31]}}, shifted_s[31:0]} : {32'd0, shifted_s[31:0]};
            SZ_D:    load_val = shifted_s;
            default: load_val = shifted_s;
        endcase

        for (int i = 0; i < 8; i++) begin
            merged[8*i +: 8] = mask_s[i] ? wshift_s[8*i +: 8] : rd_dword[8*i +: 8];
        end

        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = off[0];
            SZ_W:    misaligned = |off[1:0];
            SZ_D:    misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of Data_Memory: doubleword-aligned accesses with
// read-modify-write for narrow stores. LSU_MISALIGN_TRAP_EN traps misaligned requests.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int BITSIZE = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [BITSIZE-1:0] req_addr,
    input  logic [BITSIZE-1:0] req_wdata,
    output logic               resp_valid,
    output logic [BITSIZE-1:0] resp_rdata,
    output logic               resp_err,
    output logic [BITSIZE-1:0] dm_address,
    output logic [BITSIZE-1:0] dm_write_data,
    output logic               dm_mem_write,
    output logic               dm_mem_read,
    input  logic [BITSIZE-1:0] dm_read_data
);

    lsu_state_e         state_r, state_nx_s;
    logic               wr_r, signed_r;
    logic [1:0]         size_r;
    logic [BITSIZE-1:0] addr_r, wdata_r, rdata_r;
    logic               resp_valid_r, resp_err_r;
    logic [BITSIZE-1:0] resp_rdata_r;

    logic [2:0]         off_s, acc_off_s;
    logic [1:0]         lane_size_s;
    logic [63:0]        rd_dword_s, load_val_s, merged_s;
    logic               misaligned_s, trap_s, accept_s;

    assign accept_s   = req_valid && (state_r == IDLE);
    assign req_ready  = (state_r == IDLE);
    assign dm_address = {addr_r[BITSIZE-1:3], 3'b000};
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s    = misaligned_s;
    assign acc_off_s = req_addr[2:0];
`else
    assign trap_s    = 1'b0;
    assign acc_off_s = misaligned_s ? align_off(req_addr[2:0], req_size) : req_addr[2:0];
`endif

    // In IDLE the lane block judges the incoming request; afterwards the latched one
    always_comb begin
        if (state_r == IDLE) begin
            off_s       = req_addr[2:0];
            lane_size_s = req_size;
        end else begin
            off_s       = addr_r[2:0];
            lane_size_s = size_r;
        end
        if (state_r == RD) begin
            rd_dword_s = dm_read_data;
        end else begin
            rd_dword_s = rdata_r;
        end
    end

    lsu_lane_align u_lane (
        .off        (off_s),
        .size       (lane_size_s),
        .sgn        (signed_r),
        .rd_dword   (rd_dword_s),
        .wdata      (wdata_r),
        .load_val   (load_val_s),
        .merged     (merged_s),
        .misaligned (misaligned_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and memory strobes
    always_comb begin
        state_nx_s    = state_r;
        dm_mem_read   = 1'b0;
        dm_mem_write  = 1'b0;
        dm_write_data = '0;
        case (state_r)
            IDLE: begin
                if (!req_valid) begin
                    state_nx_s = IDLE;
                end else if (trap_s) begin
                    state_nx_s = RESP;
                end else if (!req_write) begin
                    state_nx_s = RD;
                end else if (req_size == SZ_D) begin
                    state_nx_s = WR;
                end else begin
                    state_nx_s = RD;
                end
            end
            RD: begin
                dm_mem_read = 1'b1;
                state_nx_s  = wr_r ? WR : RESP;
            end
            WR: begin
                dm_mem_write  = 1'b1;
                dm_write_data = merged_s;
                state_nx_s    = RESP;
            end
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Request latch and read-doubleword capture at the end of RD
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r     <= 1'b0;
            size_r   <= SZ_B;
            signed_r <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
        end else begin
            if (accept_s) begin
                wr_r     <= req_write;
                size_r   <= req_size;
                signed_r <= req_signed;
                addr_r   <= {req_addr[BITSIZE-1:3], acc_off_s};
                wdata_r  <= req_wdata;
            end
            if (state_r == RD) begin
                rdata_r <= dm_read_data;
            end
        end
    end

    // Registered response: valid for the single RESP cycle only
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
        end else begin
            resp_valid_r <= (state_nx_s == RESP);
            resp_err_r   <= accept_s && trap_s;
            resp_rdata_r <= (state_r == RD && !wr_r) ? load_val_s : '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-abandon
// sequence and randomized traffic against a byte-array reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] dm_address, dm_write_data, dm_read_data;
    logic        dm_mem_write, dm_mem_read;

    int checks = 0;
    int errors = 0;

    // Data_Memory stand-in (16 doublewords) with a bench preload port
    logic [63:0] mem [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [63:0] pre_val = 64'd0;

    // Reference model: flat byte array
    logic [7:0]  ref_bytes [128];

    always #5 clk = ~clk;

    assign dm_read_data = mem[dm_address[6:3]];

    always @(posedge clk) begin
        if (dm_mem_write) mem[dm_address[6:3]] <= dm_write_data;
        else if (pre_en)  mem[pre_idx] <= pre_val;
    end

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dm_address(dm_address), .dm_write_data(dm_write_data),
        .dm_mem_write(dm_mem_write), .dm_mem_read(dm_mem_read), .dm_read_data(dm_read_data)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [63:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx[3:0]; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
        for (int i = 0; i < 8; i++) ref_bytes[idx*8 + i] = val[8*i +: 8];
    endtask

    function automatic logic [63:0] ref_load(input int a, input int n, input bit sg);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < n; i++) v |= 64'(ref_bytes[a + i]) << (8 * i);
        if (sg && n < 8 && v[8*n - 1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    function automatic logic [63:0] ref_word(input int idx);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_bytes[idx*8 + i];
        return v;
    endfunction

    // One request; records strobe activity and the response cycle (lat=-1 on timeout)
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er, output int lat,
                          output int nrd, output int nwr,
                          output logic [63:0] raddr, output logic [63:0] wdat);
        bit got;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        got = 1'b0; lat = -1; nrd = 0; nwr = 0; raddr = 64'd0; wdat = 64'd0;
        rd = 64'd0; er = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (dm_mem_read)  begin nrd++; raddr = dm_address; end
            if (dm_mem_write) begin nwr++; wdat = dm_write_data; end
            if (dm_mem_read && dm_mem_write) nrd += 100;
            if (resp_valid) begin got = 1'b1; lat = c; rd = resp_rdata; er = resp_err; end
        end
        if (got) begin
            @(negedge clk);
            chk("resp_pulse_ready", {62'd0, resp_valid, req_ready}, 64'd1);
        end
    endtask

    typedef struct {
        logic        pre_en;
        logic [63:0] pre_val;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [63:0] exp_wd;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [63:0] rd, raddr, wdat, exp_rd, w64;
        logic        er, exp_err;
        int          lat, nrd, nwr, exp_lat, exp_nrd, exp_nwr, n, a, ea;
        logic        w, sg;
        logic [1:0]  sz;

        vt[0]  = '{1'b1, 64'h1122334455667788, 1'b0, 2'b00, 1'b1, 64'hF, 64'h0, 64'h11, 1'b0, 2, 64'h0};
        vt[1]  = '{1'b0, 64'h0, 1'b0, 2'b01, 1'b1, 64'hE, 64'h0, 64'h1122, 1'b0, 2, 64'h0};
        vt[2]  = '{1'b0, 64'h0, 1'b0, 2'b00, 1'b1, 64'h8, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2, 64'h0};
        vt[3]  = '{1'b1, 64'hFFEEDDCCBBAA9988, 1'b0, 2'b10, 1'b1, 64'hC, 64'h0, 64'hFFFFFFFFFFEEDDCC, 1'b0, 2, 64'h0};
        vt[4]  = '{1'b0, 64'h0, 1'b0, 2'b10, 1'b0, 64'hC, 64'h0, 64'h00000000FFEEDDCC, 1'b0, 2, 64'h0};
        vt[5]  = '{1'b0, 64'h0, 1'b0, 2'b11, 1'b1, 64'h8, 64'h0, 64'hFFEEDDCCBBAA9988, 1'b0, 2, 64'h0};
        vt[6]  = '{1'b1, 64'h1122334455667788, 1'b1, 2'b00, 1'b0, 64'hA, 64'hAB, 64'h0, 1'b0, 3, 64'h1122334455AB7788};
        vt[7]  = '{1'b0, 64'h0, 1'b1, 2'b11, 1'b0, 64'h8, 64'h3, 64'h0, 1'b0, 2, 64'h3};
        vt[8]  = '{1'b0, 64'h0, 1'b0, 2'b11, 1'b0, 64'h8, 64'h0, 64'h3, 1'b0, 2, 64'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        vt[9]  = '{1'b1, 64'h1122334455667788, 1'b1, 2'b01, 1'b0, 64'h9, 64'hBEEF, 64'h0, 1'b1, 1, 64'h0};
        vt[10] = '{1'b0, 64'h0, 1'b0, 2'b11, 1'b0, 64'h8, 64'h0, 64'h1122334455667788, 1'b0, 2, 64'h0};
`else
        vt[9]  = '{1'b1, 64'h1122334455667788, 1'b1, 2'b01, 1'b0, 64'h9, 64'hBEEF, 64'h0, 1'b0, 3, 64'h112233445566BEEF};
        vt[10] = '{1'b0, 64'h0, 1'b0, 2'b11, 1'b0, 64'h8, 64'h0, 64'h112233445566BEEF, 1'b0, 2, 64'h0};
`endif

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {59'd0, req_ready, resp_valid, resp_err, dm_mem_write, dm_mem_read}, 64'h10);
        chk("reset_rdata", resp_rdata, 64'd0);
        chk("reset_dm_addr", dm_address, 64'd0);
        chk("reset_dm_wdata", dm_write_data, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) set_word(i, {$urandom, $urandom});

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            if (vt[i].pre_en) set_word(1, vt[i].pre_val);
            do_req(vt[i].wr, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, rd, er, lat, nrd, nwr, raddr, wdat);
            chk("vec_rdata", rd, vt[i].exp_rd);
            chk("vec_err", {63'd0, er}, {63'd0, vt[i].exp_err});
            chk("vec_latency", 64'(lat), 64'(vt[i].exp_lat));
            if (vt[i].wr && !vt[i].exp_err) chk("vec_wdata", wdat, vt[i].exp_wd);
            if (vt[i].exp_err || !vt[i].wr) chk("vec_no_write", 64'(nwr), 64'd0);
            if (!vt[i].wr) chk("vec_rd_addr", raddr, {vt[i].addr[63:3], 3'b000});
        end

        // Reset while a byte store is in its read phase
        set_word(1, 64'h1122334455667788);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 64'hA; req_wdata = 64'hAB;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abandon_in_rd", {63'd0, dm_mem_read}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abandon_state", {59'd0, req_ready, resp_valid, resp_err, dm_mem_write, dm_mem_read}, 64'h10);
        chk("abandon_dm_addr", dm_address, 64'd0);
        nwr = 0; nrd = 0;
        repeat (5) begin
            @(negedge clk);
            if (dm_mem_write) nwr++;
            if (resp_valid) nrd++;
        end
        chk("abandon_quiet", {32'(nwr), 32'(nrd)}, 64'd0);
        chk("abandon_mem", mem[1], 64'h1122334455667788);

        // Randomized traffic against the byte-array model
        for (int i = 0; i < 16; i++) set_word(i, {$urandom, $urandom});
        for (int t = 0; t < 250; t++) begin
            w  = $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3));
            sg = $urandom_range(0, 1);
            a  = $urandom_range(0, 127);
            w64 = {$urandom, $urandom};
            n  = 1 << sz;
            ea = a - (a % n);
            exp_err = 1'b0; exp_rd = 64'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            if (a % n != 0) begin
                exp_err = 1'b1; exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
            end else
`endif
            if (!w) begin
                exp_rd = ref_load(ea, n, sg); exp_lat = 2; exp_nrd = 1; exp_nwr = 0;
            end else begin
                for (int b = 0; b < n; b++) ref_bytes[ea + b] = w64[8*b +: 8];
                exp_lat = (n == 8) ? 3 - 1 : 3; exp_nrd = (n == 8) ? 0 : 1; exp_nwr = 1;
            end
            do_req(w, sz, sg, 64'(a), w64, rd, er, lat, nrd, nwr, raddr, wdat);
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_err", {63'd0, er}, {63'd0, exp_err});
            chk("rnd_latency", 64'(lat), 64'(exp_lat));
            chk("rnd_strobes", {32'(nrd), 32'(nwr)}, {32'(exp_nrd), 32'(exp_nwr)});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 16; i++) chk("rnd_mem", mem[i], ref_word(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of Data_Memory and is the only block that drives it.
- Accepts load/store requests from the execute stage with a size of byte, half, word or doubleword, plus a sign flag for loads.
- Translates each request into doubleword-aligned Data_Memory accesses. Sub-doubleword stores are done as read-modify-write.
- Returns extracted, sign- or zero-extended load data through a valid pulse.

Parameters:
- BITSIZE, 64, data/address width. The lane logic requires exactly 64.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword
- req_signed  in  1  loads only: sign-extend the result
- req_addr  in  BITSIZE  byte address
- req_wdata  in  BITSIZE  store data, taken from the low bytes of the given size
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  BITSIZE  load result; 0 for stores and errors
- resp_err  out  1  misaligned access, valid with resp_valid
- dm_address  out  BITSIZE  to Data_Memory address, always {addr[63:3],3'b000}
- dm_write_data  out  BITSIZE  to Data_Memory writeData
- dm_mem_write  out  1  to Data_Memory memWrite
- dm_mem_read  out  1  to Data_Memory memRead
- dm_read_data  in  BITSIZE  from Data_Memory readData

Behaviour:
- Clocking: one clock (clk). Reset (rst) is synchronous and active-high.
- Handshake:
  - Accept when req_valid && req_ready at a rising edge; request fields are latched at that edge.
  - No backpressure on the response. resp_valid is high for exactly one cycle per accepted request.
- FSM states: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - load -> RD
  - store with size 11 -> WR
  - store with size below 11 -> RD (read-modify-write)
  - misaligned (see Optional Feature) -> RESP with err
- Further transitions: RD (load) -> RESP; RD (store) -> WR; WR -> RESP; RESP -> IDLE.
- Strobes (combinational from state and latched request):
  - RD: dm_mem_read=1.
  - WR: dm_mem_write=1, dm_write_data = merged doubleword.
  - Otherwise both strobes are 0 and dm_write_data = 0.
  - The two strobes are never high together.
- dm_read_data is sampled at the rising edge that ends RD.
- Latency from the accept edge to resp_valid:
  - load: 2 cycles
  - doubleword store: 2 cycles
  - sub-doubleword store: 3 cycles
  - error: 1 cycle
- Lanes (little-endian, off = addr[2:0]):
  - Load extract: field = dm_read_data >> (8*off), masked to 8, 16, 32 or 64 bits. Sign-extended when req_signed=1, else zero-extended. req_signed is ignored for size 11.
  - Store merge: the bytes [off, off+size) of the read doubleword are replaced by the low bytes of req_wdata; all other bytes are preserved bit-exact.
- Alignment: natural alignment is required (half: off[0]=0; word: off[1:0]=0; double: off=0), so no access ever crosses a doubleword.
- Reset values, and state on any cycle following a rst edge:
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all dm_* outputs 0.
  - Reset in RD abandons the request with no write. Reset in WR completes no further write beyond that cycle. No response is issued for an abandoned request.
- req_valid is ignored in every state other than IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request issues no memory strobes and goes IDLE->RESP with resp_err=1 and resp_rdata=0.
- Undefined: low address bits are forced to alignment (half clears bit0, word clears [1:0], double clears [2:0]), the access proceeds normally, and resp_err is tied 0.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D
  - state enum for IDLE/RD/WR/RESP
  - function size_bytes(size) returning 1/2/4/8
- One sub-module, lsu_lane_align (combinational), takes off, size, signed, the read doubleword and wdata. It outputs the extended load value, the merged store doubleword and a misaligned flag.
- The FSM, registers and strobes stay in load_store_unit.

Test Plan:
- Memory word 0x8 preset to 0x1122334455667788; signed byte load at addr 0xF -> resp_rdata=0x0000000000000011 two cycles after accept; dm_address=0x8 during RD.
- Same word; signed half load at addr 0xE -> 0x0000000000001122. Preset 0xFFEE...; signed word load at addr 0xC -> 0xFFFFFFFFFFEE... sign-filled. Unsigned load of the same word -> upper 32 bits zero.
- Byte store of 0xAB at addr 0xA into word 0x8 = 0x1122334455667788 -> one RD, then WR with dm_write_data=0x1122334455AB7788; resp_valid three cycles after accept.
- Doubleword store of 0x3 at addr 0x8 -> no RD cycle; WR in the first cycle after accept; resp_valid in the second.
- Half store at addr 0x9 -> with LSU_MISALIGN_TRAP_EN: resp_err=1 after one cycle and dm_mem_write never asserted; without: write lands at byte offset 0x8.
- rst asserted during RD of a byte store -> next cycle IDLE, req_ready=1, dm_mem_write stays 0, no resp_valid, memory unchanged.
